// File: rtl/mem_stage_data_responder_if.sv
// Pipeline-to-memory-stage bus for mem_stage_data_responder.
//   master : EX/MEM side; drives address, store data, op and size, and
//            receives the stall, load result and alignment flag.
//   slave  : the responder itself.
// Signal names follow the pipeline register naming used by the core.
interface mem_stage_data_responder_if;
    logic [31:0] AddressIn;
    logic [31:0] WriteDataIn;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic [1:0]  bytes2LoadIn;
    logic [1:0]  bytes2StoreIn;
    logic        LoadSignedIn;
    logic        StallOut;
    logic [31:0] LoadDataOut;
    logic        LoadValidOut;
    logic        AlignErrOut;

    modport master (
        output AddressIn, WriteDataIn, MemReadIn, MemWriteIn,
        output bytes2LoadIn, bytes2StoreIn, LoadSignedIn,
        input  StallOut, LoadDataOut, LoadValidOut, AlignErrOut
    );

    modport slave (
        input  AddressIn, WriteDataIn, MemReadIn, MemWriteIn,
        input  bytes2LoadIn, bytes2StoreIn, LoadSignedIn,
        output StallOut, LoadDataOut, LoadValidOut, AlignErrOut
    );
endinterface

// File: rtl/mem_stage_data_responder.sv
// Memory-stage data responder: owns the data RAM and services byte, halfword
// and word loads/stores from the EX/MEM register with WAIT_STATES extra busy
// cycles per access.
// Ports:
//   Clk      : clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : slave modport of mem_stage_data_responder_if
//              (address/data/op/size in; stall, load data/valid, align error out)
module mem_stage_data_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic                          Clk,
    input logic                          Reset_n,
    mem_stage_data_responder_if.slave    bus
);

    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit          ZeroWait = (WAIT_STATES == 0);
    localparam logic [3:0]  WaitInit = ZeroWait ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    // Registered state
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d;
    logic              sign_q, sign_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;

    logic [31:0]       mem [DEPTH_WORDS];

    // Request decode on the live inputs
    logic              req;
    logic              req_wr;
    logic [1:0]        req_size;
    logic [IdxW-1:0]   req_idx;
    logic [1:0]        req_off;
    logic              req_misaligned;
    logic              idle;
    logic              accept;

    // Access fields used at commit time (live inputs for a zero-wait access)
    logic [IdxW-1:0]   c_idx;
    logic [1:0]        c_off;
    logic [31:0]       c_wdata;
    logic [1:0]        c_size;
    logic              c_wr;
    logic              c_sign;
    logic              commit;
    logic [3:0]        c_be;
    logic [31:0]       c_wlane;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;

    // Address bits above the RAM index are deliberately dropped (addresses wrap).
    logic              unused_addr_bits;
    assign unused_addr_bits = ^bus.AddressIn[31:IdxW+2];

    always_comb begin
        req      = bus.MemReadIn | bus.MemWriteIn;
        // A simultaneous read and write performs only the write.
        req_wr   = bus.MemWriteIn;
        req_size = req_wr ? bus.bytes2StoreIn : bus.bytes2LoadIn;
        req_idx  = bus.AddressIn[IdxW+1:2];
        req_off  = bus.AddressIn[1:0];
        unique case (req_size)
            2'b01:   req_misaligned = req_off[0];
            2'b10:   req_misaligned = 1'b0;
            default: req_misaligned = (req_off != 2'b00);
        endcase
        idle   = (state_q == StIdle);
        accept = Reset_n & idle & req & ~req_misaligned;
    end

    always_comb begin
        if (idle) begin
            c_idx   = req_idx;
            c_off   = req_off;
            c_wdata = bus.WriteDataIn;
            c_size  = req_size;
            c_wr    = req_wr;
            c_sign  = bus.LoadSignedIn;
        end else begin
            c_idx   = idx_q;
            c_off   = off_q;
            c_wdata = wdata_q;
            c_size  = size_q;
            c_wr    = wr_q;
            c_sign  = sign_q;
        end
        // Reset_n gating keeps an aborted store from landing while reset is held.
        commit = Reset_n & ((ZeroWait & accept) | ((state_q == StWait) & (cnt_q == 4'd0)));
    end

    // Store lane steering: replicate the right-justified data across lanes and
    // enable only the addressed ones.
    always_comb begin
        unique case (c_size)
            2'b10: begin
                c_wlane = {4{c_wdata[7:0]}};
                c_be    = 4'b0001 << c_off;
            end
            2'b01: begin
                c_wlane = {2{c_wdata[15:0]}};
                c_be    = c_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                c_wlane = c_wdata;
                c_be    = 4'b1111;
            end
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        rd_word  = mem[c_idx];
        rd_shift = rd_word >> {c_off, 3'b000};
        unique case (c_size)
            2'b10:   rd_ext = c_sign ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                     : {24'h000000, rd_shift[7:0]};
            2'b01:   rd_ext = c_sign ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                     : {16'h0000, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        wr_d         = wr_q;
        sign_d       = sign_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    idx_d   = req_idx;
                    off_d   = req_off;
                    wdata_d = bus.WriteDataIn;
                    size_d  = req_size;
                    wr_d    = req_wr;
                    sign_d  = bus.LoadSignedIn;
                    if (ZeroWait) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                // Pipeline register advances at the end of this cycle.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (commit && !c_wr) begin
            load_data_d  = rd_ext;
            load_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            size_q       <= 2'b00;
            wr_q         <= 1'b0;
            sign_q       <= 1'b0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            wr_q         <= wr_d;
            sign_q       <= sign_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge Clk) begin
        if (commit && c_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wlane[8*i +: 8];
                end
            end
        end
    end

    assign bus.StallOut     = accept | (Reset_n & (state_q == StWait));
    assign bus.AlignErrOut  = Reset_n & idle & req & req_misaligned;
    assign bus.LoadDataOut  = load_data_q;
    assign bus.LoadValidOut = load_valid_q;

endmodule
